// File: rtl/arith_pkg.sv
// Shared types and constants for the sequential sum/multiply stage.
// Holds the FSM encoding and the default operand width.
package arith_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Counter width; at least one bit so WIDTH=1 still elaborates.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add multiplier datapath: one partial product per step.
// acc_nxt exposes the accumulator including the current step's add.
module seq_mult_datapath
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               last_step
);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;
    assign last_step = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/seq_sum_mult.sv
// Registered sum plus multi-cycle product behind valid/ready handshakes.
// FSM and handshake live here; the multiplier datapath is a sub-module.
module seq_sum_mult
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     sum,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic               step;
    logic               last_step;
    logic [2*WIDTH-1:0] acc_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sum     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                sum <= {1'b0, a} + {1'b0, b};
            end
            // Final iteration: capture the accumulator with its last add.
            if (step && last_step) begin
                product <= acc_nxt;
            end
        end
    end

    seq_mult_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .a        (a),
        .b        (b),
        .acc_nxt  (acc_nxt),
        .last_step(last_step)
    );

endmodule

// File: tb/tb_seq_sum_mult.sv
// Directed testbench for seq_sum_mult at WIDTH=8.
module tb_seq_sum_mult;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  sum;
    logic [15:0] product;
    logic        busy;

    int errors;
    int checks;

    seq_sum_mult #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .product  (product),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          output int cycles);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(cycles);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (sum !== 9'd0 || product !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: sum=%0d product=%0d want 0 0", sum, product);
        end
        // reset wins over a simultaneous handshake
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 8'd5;
        b        = 8'd6;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || sum !== 9'd0) begin
            errors++;
            $display("FAIL reset_vs_valid: busy=%b in_ready=%b sum=%0d want 0 1 0",
                     busy, in_ready, sum);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || sum !== 9'd0) begin
            errors++;
            $display("FAIL reset_vs_valid_after: busy=%b sum=%0d want 0 0", busy, sum);
        end
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b0;
        a         = 8'd10;
        b         = 8'd99;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: busy=%b in_ready=%b out_valid=%b want 1 0 0",
                     busy, in_ready, out_valid);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL basic_latency: cycles=%0d want 8", cyc);
        end
        checks++;
        if (sum !== 9'd109 || product !== 16'd990) begin
            errors++;
            $display("FAIL basic_result: sum=%0d product=%0d want 109 990", sum, product);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (sum !== 9'd109 || product !== 16'd990) begin
            errors++;
            $display("FAIL basic_retain: sum=%0d product=%0d want 109 990", sum, product);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready = 1'b1;
        run_op(8'd132, 8'd33, cyc);
        checks++;
        if (cyc != 8 || sum !== 9'd165 || product !== 16'd4356) begin
            errors++;
            $display("FAIL b2b_first: cycles=%0d sum=%0d product=%0d want 8 165 4356",
                     cyc, sum, product);
        end
        a        = 8'd33;
        b        = 8'd4;
        in_valid = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || sum !== 9'd37) begin
            errors++;
            $display("FAIL b2b_accept2: busy=%b sum=%0d want 1 37", busy, sum);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 8 || sum !== 9'd37 || product !== 16'd132) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d sum=%0d product=%0d want 8 37 132",
                     cyc, sum, product);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_one_cycle: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_boundary();
        int cyc;
        out_ready = 1'b1;
        run_op(8'd255, 8'd255, cyc);
        checks++;
        if (cyc != 8 || sum !== 9'd510 || product !== 16'd65025) begin
            errors++;
            $display("FAIL max_ops: cycles=%0d sum=%0d product=%0d want 8 510 65025",
                     cyc, sum, product);
        end
        tick();
        run_op(8'd0, 8'd77, cyc);
        checks++;
        if (cyc != 8 || sum !== 9'd77 || product !== 16'd0) begin
            errors++;
            $display("FAIL zero_op: cycles=%0d sum=%0d product=%0d want 8 77 0",
                     cyc, sum, product);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        run_op(8'd12, 8'd5, cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL bp_latency: cycles=%0d want 8", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            a        = 8'(99 + i);
            b        = 8'd1;
            in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                sum !== 9'd17 || product !== 16'd60) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ov=%b ir=%b sum=%0d product=%0d want 1 0 17 60",
                         i, out_valid, in_ready, sum, product);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || sum !== 9'd17 || product !== 16'd60) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b sum=%0d product=%0d want 1 17 60",
                     in_ready, sum, product);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        out_ready = 1'b1;
        a         = 8'd200;
        b         = 8'd3;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== 9'd0 || product !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: ir=%b ov=%b busy=%b sum=%0d product=%0d want 1 0 0 0 0",
                     in_ready, out_valid, busy, sum, product);
        end
        run_op(8'd2, 8'd3, cyc);
        checks++;
        if (cyc != 8 || sum !== 9'd5 || product !== 16'd6) begin
            errors++;
            $display("FAIL post_reset_op: cycles=%0d sum=%0d product=%0d want 8 5 6",
                     cyc, sum, product);
        end
        tick();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_sum_mult.md
Name: seq_sum_mult

Overview:
- Registered arithmetic stage that consumes an operand pair (a, b) and produces its sum and product for the downstream monitor/display logic.
- Replaces combinational multiply with a multi-cycle shift-add multiplier behind valid/ready handshakes on both sides.
- Sits directly upstream of the sum/product consumer; the stimulus/operand source drives its input side.

Parameters:
- WIDTH, 8, operand width in bits; sum is WIDTH+1 bits, product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand 1, unsigned.
- b  input  WIDTH  operand 2, unsigned.
- out_valid  output  1  sum/product hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH+1  registered a+b, unsigned, no overflow.
- product  output  2*WIDTH  registered a*b, unsigned, no overflow.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset, sampled on a rising edge only: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, product=0, internal accumulator, shift registers and counter cleared.
- Reset has priority over every other event, including a handshake on the same edge.
- FSM states are IDLE, CALC and DONE. in_ready=(state==IDLE). out_valid=(state==DONE). busy=(state!=IDLE).
- IDLE:
  - On an edge with in_valid&&in_ready: latch mcand<=zero-extended a (2*WIDTH bits) and mplier<=b.
  - Same edge: sum<=a+b, acc<=0, count<=0, go to CALC.
  - Without in_valid: stay in IDLE; sum/product keep their last values.
- CALC, one iteration per edge:
  - if mplier[0], acc<=acc+mcand; then mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - On the edge where count==WIDTH-1, that final iteration completes: product<=final acc value, including this last add, and go to DONE.
  - CALC lasts exactly WIDTH cycles regardless of operand values. No early exit.
- Latency: acceptance at edge E0 -> out_valid high after edge E0+WIDTH (8 cycles at default).
- DONE:
  - sum/product stable, out_valid=1.
  - On an edge with out_ready: go to IDLE, out_valid=0; sum/product retain their values.
  - If out_ready is already high on entry, out_valid is high for exactly one cycle.
  - out_ready low holds DONE indefinitely (backpressure); in_ready stays 0.
- in_valid while busy is ignored. The source holds a/b stable until accepted. No back-to-back acceptance in DONE; throughput is 1 result per WIDTH+2 cycles minimum.
- sum and product are never truncated. Maximum at WIDTH=8: sum=510 (0x1FE), product=65025 (0xFE01).
- out_ready while not in DONE has no effect.
- Reset mid-CALC or mid-DONE aborts the operation. The result is discarded and all outputs return to reset values after that edge.

Decomposition:
- Shared package arith_pkg:
  - state typedef enum {IDLE, CALC, DONE}
  - default operand width constant (8)
  - count width derived as $clog2(WIDTH)
- One natural sub-module, seq_mult_datapath: holds mcand/mplier/acc/count, with load/step controls and a last_step flag. The FSM and handshake logic stay in seq_sum_mult.

Test Plan:
- After reset with a=10, b=99, in_valid pulsed -> after 8 cycles out_valid=1, sum=109, product=990; out_ready=1 -> IDLE, in_ready=1 next cycle.
- a=132, b=33, then a=33, b=4 as back-to-back transactions with out_ready held high -> sum=165/product=4356, then sum=37/product=132; second acceptance exactly 1 cycle after the first DONE.
- a=255, b=255 -> sum=510, product=65025. a=0, b=77 -> sum=77, product=0, still exactly 8 CALC cycles.
- a=12, b=5 with out_ready held low 5 cycles after DONE -> out_valid, sum=17, product=60 stable all 5 cycles; in_ready=0; in_valid pulses with other operands ignored.
- Accept a=200, b=3, assert reset on the 4th CALC edge -> next cycle in_ready=1, out_valid=0, busy=0, sum=0, product=0. A following a=2, b=3 yields sum=5, product=6.
- Reset and in_valid high on the same edge -> no acceptance; state IDLE, sum=0.
